// File: rtl/cm_sketch_pkg.sv
// Shared count-min sketch types and constants.
// The default sizes are also used by the hash stage.
package cm_sketch_pkg;

  localparam int unsigned CM_W         = 4096;
  localparam int unsigned CM_NUM_HASH  = 4;
  localparam int unsigned CM_CNT_SIZE  = 32;
  localparam int unsigned CM_ADDR_SIZE = 22;
  localparam int unsigned CM_DROP_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } cm_state_e;

  // Increment v, treated as a w-bit value, holding at all-ones.
  // Callers zero-extend on the way in and truncate on the way out.
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] ones;
    logic [63:0] vm;
    ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    vm   = v & ones;
    return (vm == ones) ? vm : ((vm + 64'd1) & ones);
  endfunction

endpackage

// File: rtl/cm_sketch_row.sv
// One sketch row: counter RAM, previous-write bypass,
// saturating increment and the sweep write mux.
module cm_sketch_row
  import cm_sketch_pkg::*;
#(
  parameter int unsigned W         = CM_W,
  parameter int unsigned HASH_SIZE = $clog2(W),
  parameter int unsigned CNT_SIZE  = CM_CNT_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en_i,
  input  logic [HASH_SIZE-1:0] rd_idx_i,
  input  logic                 upd_i,
  input  logic                 clr_i,
  input  logic [HASH_SIZE-1:0] clr_idx_i,
  output logic [CNT_SIZE-1:0]  new_o
);

  logic [CNT_SIZE-1:0]  mem [W];
  logic [CNT_SIZE-1:0]  rd_q;
  logic [HASH_SIZE-1:0] idx_q;
  logic                 byp_vld_q;
  logic [HASH_SIZE-1:0] byp_idx_q;
  logic [CNT_SIZE-1:0]  byp_val_q;

  logic [CNT_SIZE-1:0]  old_val;
  logic [CNT_SIZE-1:0]  new_val;
  logic                 we;
  logic [HASH_SIZE-1:0] waddr;
  logic [CNT_SIZE-1:0]  wdata;

  always_comb begin
    old_val = rd_q;
    if (byp_vld_q && (byp_idx_q == idx_q)) begin
      old_val = byp_val_q;
    end
    new_val = CNT_SIZE'(sat_inc(64'(old_val), CNT_SIZE));
  end

  always_comb begin
    we    = upd_i | clr_i;
    waddr = clr_i ? clr_idx_i : idx_q;
    wdata = clr_i ? '0 : new_val;
  end

  // Write lands after the read at the same edge, so a
  // same-index read returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_q <= mem[rd_idx_i];
    end
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      byp_vld_q <= 1'b0;
      byp_idx_q <= '0;
      byp_val_q <= '0;
    end else begin
      if (rd_en_i) begin
        idx_q <= rd_idx_i;
      end
      byp_vld_q <= upd_i & ~clr_i;
      byp_idx_q <= idx_q;
      byp_val_q <= new_val;
    end
  end

  assign new_o = new_val;

endmodule

// File: rtl/cm_sketch_update.sv
// Count-min sketch counter stage: per-row RMW, min estimate,
// and the drain/clear sweep controller.
module cm_sketch_update
  import cm_sketch_pkg::*;
#(
  parameter int unsigned W         = CM_W,
  parameter int unsigned NUM_HASH  = CM_NUM_HASH,
  parameter int unsigned HASH_SIZE = $clog2(W),
  parameter int unsigned ADDR_SIZE = CM_ADDR_SIZE,
  parameter int unsigned CNT_SIZE  = CM_CNT_SIZE,
  parameter int unsigned DROP_SIZE = CM_DROP_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [ADDR_SIZE-1:0] in_addr,
  input  logic [HASH_SIZE-1:0] in_hash [0:NUM_HASH-1],
  input  logic                 clear_req,
  output logic                 out_valid,
  output logic [ADDR_SIZE-1:0] out_addr,
  output logic [CNT_SIZE-1:0]  out_estimate,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [DROP_SIZE-1:0] drop_cnt
);

  cm_state_e            state_q, state_d;
  logic [HASH_SIZE-1:0] clr_idx_q, clr_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DROP_SIZE-1:0] drop_q;

  logic                 m_vld_q;
  logic [ADDR_SIZE-1:0] m_addr_q;
  logic                 o_vld_q;
  logic [ADDR_SIZE-1:0] o_addr_q;
  logic [CNT_SIZE-1:0]  o_est_q;

  logic                 accept;
  logic                 drop;
  logic                 clr_we;
  logic [CNT_SIZE-1:0]  new_val [NUM_HASH];
  logic [CNT_SIZE-1:0]  min_val;

  assign accept = in_valid & ~busy_q;
  assign drop   = in_valid & busy_q;
  assign clr_we = (state_q == CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
      CLEAR: begin
        if (clr_idx_q == HASH_SIZE'(W - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + HASH_SIZE'(1);
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_SIZE'(1);
      end
    end
  end

  for (genvar r = 0; r < NUM_HASH; r++) begin : g_row
    cm_sketch_row #(
      .W         (W),
      .HASH_SIZE (HASH_SIZE),
      .CNT_SIZE  (CNT_SIZE)
    ) u_row (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en_i   (accept),
      .rd_idx_i  (in_hash[r]),
      .upd_i     (m_vld_q),
      .clr_i     (clr_we),
      .clr_idx_i (clr_idx_q),
      .new_o     (new_val[r])
    );
  end

  always_comb begin
    min_val = new_val[0];
    for (int r = 1; r < NUM_HASH; r++) begin
      if (new_val[r] < min_val) begin
        min_val = new_val[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q  <= 1'b0;
      m_addr_q <= '0;
      o_vld_q  <= 1'b0;
      o_addr_q <= '0;
      o_est_q  <= '0;
    end else begin
      m_vld_q <= accept;
      if (accept) begin
        m_addr_q <= in_addr;
      end
      o_vld_q <= m_vld_q;
      if (m_vld_q) begin
        o_addr_q <= m_addr_q;
        o_est_q  <= min_val;
      end
    end
  end

  assign out_valid    = o_vld_q;
  assign out_addr     = o_addr_q;
  assign out_estimate = o_est_q;
  assign clear_busy   = busy_q;
  assign clear_done   = done_q;
  assign drop_cnt     = drop_q;

endmodule

// File: doc/cm_sketch_update.md
# cm_sketch_update

Count-min sketch counter stage, directly downstream of the hash stage. For each valid address with its NUM_HASH row indices it does three things: read-modify-writes one saturating counter per row, forwards back-to-back same-index updates, and emits the post-increment minimum as the frequency estimate. An internal sweep FSM zeroes all counters after reset and on request.

## Interface
- W, 4096: counters per row
- NUM_HASH, 4: number of rows
- HASH_SIZE, $clog2(W): row index width
- ADDR_SIZE, 22: tracked address width
- CNT_SIZE, 32: counter width
- DROP_SIZE, 16: drop counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  hash stage output valid
- in_addr  in  ADDR_SIZE  address from hash stage
- in_hash  in  HASH_SIZE x NUM_HASH  unpacked [0:NUM_HASH-1] row indices
- clear_req  in  1  single-cycle request to zero all counters
- out_valid  out  1  estimate valid
- out_addr  out  ADDR_SIZE  address of estimate
- out_estimate  out  CNT_SIZE  min over rows of post-increment counts
- clear_busy  out  1  high while draining or clearing; inputs are dropped
- clear_done  out  1  one-cycle pulse when a sweep completes
- drop_cnt  out  DROP_SIZE  saturating count of dropped in_valid beats

## Operation
- No backpressure. The hash stage never stalls. A beat with in_valid=1 while clear_busy=1 is dropped, and drop_cnt += 1, saturating at all-ones.
- FSM states: IDLE, DRAIN, CLEAR.
  - Reset enters CLEAR with sweep index 0.
  - IDLE → DRAIN on clear_req. A beat presented in that same cycle is accepted.
  - DRAIN lasts one cycle, so the last accepted beat can perform its write.
  - CLEAR writes 0 to index k of every row, one index per cycle, for k = 0..W-1, then returns to IDLE.
  - clear_req outside IDLE is ignored.
- Each row has a 1-read/1-write RAM. Reads have 1-cycle latency. Read-during-write to the same index returns the old data.
- Per-row bypass register holds {valid, index, value} of the write performed in the previous cycle.
  - The bypass is invalidated whenever no update write occurs, which includes every CLEAR cycle.
  - If the bypass index equals the stage-M index, the bypass value replaces the RAM data.
- Increment: new = (old == all-ones) ? old : old + 1, computed CNT_SIZE wide with no widening.
- Estimate: unsigned min over NUM_HASH new values. Ties are irrelevant.
- RAM contents are not reset. The sweep on reset provides the zero state.

## Timing
- Cycle t: beat accepted. Read issued at in_hash[r] for each row. Index and address are registered.
- Cycle t+1 (stage M): read data plus bypass selects the old value, new is computed, the write is issued for every row, and the min is computed.
- Edge ending t+1: out_valid=1, out_addr and out_estimate registered. Latency is 2 cycles, throughput is 1 beat per cycle.
- Same index at t and t+1: the second beat sees the first beat's new value through the bypass. A gap of two or more cycles reads the RAM directly.
- clear_req at cycle c:
  - DRAIN at c+1.
  - CLEAR during cycles c+2 .. c+W+1.
  - clear_done pulses at c+W+2 (the IDLE-entry cycle), and clear_busy falls in that cycle.
  - A beat at c+W+2 is accepted.
- clear_busy is registered, high in DRAIN and CLEAR.
- Mid-operation async reset: the pipeline is flushed and no out_valid is produced for in-flight beats. Then a fresh sweep of W cycles runs, with first acceptance W cycles after deassertion.
- Reset values: out_valid 0, out_addr 0, out_estimate 0, clear_busy 1, clear_done 0, drop_cnt 0.

## Structure
- The shared package cm_sketch_pkg holds:
  - the state enum (IDLE/DRAIN/CLEAR);
  - the sat_inc function, parameterised by width;
  - default W/NUM_HASH/CNT_SIZE constants, which are shared with the hash stage.
- Sub-module cm_sketch_row, instantiated NUM_HASH times via generate:
  - contains the RAM, bypass register, saturating increment and clear-write mux;
  - outputs the stage-M new value.
- The top level holds the FSM, sweep counter, drop counter, input/address pipeline and min tree.

## Test plan
Run with W=16, NUM_HASH=4, CNT_SIZE=8.
- After reset, check clear_busy=1 for 16 cycles, then clear_done pulses once. A single beat with hashes {1,2,3,4} → out_valid after 2 cycles with estimate 1.
- Same addr/hashes on 5 consecutive cycles → estimates 1,2,3,4,5. This verifies the bypass with no lost updates.
- Alternate A={0,0,0,0} and B={0,5,6,7} for 4 beats each → B's first estimate is 1. The row-0 counter reaches 8, and the estimates are the min of the rows.
- Issue 300 beats on the same hashes. The estimate saturates at 255 and stays at 255.
- Pulse clear_req with in_valid held high. The beat in the clear_req cycle is accepted, the next 17 beats are dropped (drop_cnt=17), and clear_done pulses. The next beat's estimate is 1.
- Assert rst_n low for 1 cycle with beats in flight. No out_valid is produced for them, all outputs take their reset values, and the sweep reruns.
